// File: rtl/adc_capture_core.sv
// ADC sample capture engine: synchronises converter strobes into the bus clock
// domain, decimates, buffers samples in a FIFO and serves single-word reads.
module adc_capture_core #(
  parameter int unsigned ADC_WIDTH  = 10,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic                  SPLB_Clk,
  input  logic                  SPLB_Rst,
  input  logic [ADC_WIDTH-1:0]  ADC_Data,
  input  logic                  ADC_OTR,
  input  logic                  ADC_DClk,
  output logic                  ADC_PWRDN,
  input  logic                  Ctl_PwrDn,
  input  logic                  Ctl_Start,
  input  logic                  Ctl_Stop,
  input  logic [7:0]            Ctl_Decim,
  input  logic [DEPTH_LOG2:0]   Ctl_Count,
  input  logic                  Rd_Req,
  output logic                  Rd_Ack,
  output logic [0:31]           Rd_Data,
  output logic                  Stat_Busy,
  output logic                  Stat_Done,
  output logic                  Stat_Overflow,
  output logic [DEPTH_LOG2:0]   Stat_Level,
  output logic                  Capture_Irq
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   ONE_CNT    = 1;
  localparam logic [DEPTH_LOG2-1:0] ONE_PTR    = 1;

  typedef enum logic [1:0] {IDLE, CAPTURE, DONE} stateT;

  stateT state, nextState;

  logic                  dclkMeta, dclkSync, dclkHist;
  logic [ADC_WIDTH-1:0]  dataP1, dataP2;
  logic                  otrP1, otrP2;
  logic                  sampleEvent;

  logic [7:0]            decimCnt;
  logic [DEPTH_LOG2:0]   storedCnt;
  logic [DEPTH_LOG2:0]   level;
  logic [DEPTH_LOG2-1:0] wrPtr, rdPtr;
  logic [ADC_WIDTH:0]    mem [DEPTH];
  logic [ADC_WIDTH:0]    headEntry;
  logic [0:31]           readWord;

  logic capturing, keepSample, fifoFull, fifoEmpty;
  logic doWrite, doDrop, doPop, countHit;

  // Data pipeline depth matches the strobe synchroniser so the event cycle
  // sees the word that was on the pins when DClk rose.
  always_ff @(posedge SPLB_Clk) begin
    if (SPLB_Rst) begin
      dclkMeta <= 1'b0;
      dclkSync <= 1'b0;
      dclkHist <= 1'b0;
      dataP1   <= '0;
      dataP2   <= '0;
      otrP1    <= 1'b0;
      otrP2    <= 1'b0;
    end else begin
      dclkMeta <= ADC_DClk;
      dclkSync <= dclkMeta;
      dclkHist <= dclkSync;
      dataP1   <= ADC_Data;
      dataP2   <= dataP1;
      otrP1    <= ADC_OTR;
      otrP2    <= otrP1;
    end
  end

  assign sampleEvent = dclkSync & ~dclkHist;
  assign capturing   = (state == CAPTURE);
  assign keepSample  = sampleEvent && capturing && (decimCnt == Ctl_Decim);
  assign fifoFull    = (level == FULL_LEVEL);
  assign fifoEmpty   = (level == '0);
  assign doWrite     = keepSample && !fifoFull && !Ctl_Start;
  assign doDrop      = keepSample && fifoFull && !Ctl_Start;
  assign doPop       = Rd_Req && !fifoEmpty && !Ctl_Start;

  // The final write and the move to DONE land on the same edge, so no
  // further sample can slip in behind the requested count.
  always_comb begin
    countHit = 1'b0;
    if (Ctl_Count != '0) begin
      if (doWrite) countHit = ((storedCnt + ONE_CNT) == Ctl_Count);
      else         countHit = (storedCnt >= Ctl_Count);
    end
  end

  always_comb begin
    nextState = state;
    if (Ctl_Start) begin
      nextState = CAPTURE;
    end else begin
      case (state)
        CAPTURE: if (Ctl_Stop || countHit) nextState = DONE;
        default: nextState = state;
      endcase
    end
  end

  always_ff @(posedge SPLB_Clk) begin
    if (doWrite) mem[wrPtr] <= {otrP2, dataP2};
  end

  assign headEntry = mem[rdPtr];

  always_comb begin
    readWord                   = '0;
    readWord[0]                = 1'b1;
    readWord[1]                = headEntry[ADC_WIDTH];
    readWord[32-ADC_WIDTH:31]  = headEntry[ADC_WIDTH-1:0];
  end

  always_ff @(posedge SPLB_Clk) begin
    if (SPLB_Rst) begin
      state         <= IDLE;
      decimCnt      <= '0;
      storedCnt     <= '0;
      level         <= '0;
      wrPtr         <= '0;
      rdPtr         <= '0;
      Stat_Overflow <= 1'b0;
      Capture_Irq   <= 1'b0;
      ADC_PWRDN     <= 1'b1;
      Rd_Ack        <= 1'b0;
      Rd_Data       <= '0;
    end else begin
      state       <= nextState;
      Capture_Irq <= (state != DONE) && (nextState == DONE);
      ADC_PWRDN   <= Ctl_PwrDn;
      Rd_Ack      <= Rd_Req;
      Rd_Data     <= doPop ? readWord : '0;

      if (Ctl_Start) begin
        decimCnt      <= '0;
        storedCnt     <= '0;
        level         <= '0;
        wrPtr         <= '0;
        rdPtr         <= '0;
        Stat_Overflow <= 1'b0;
      end else begin
        if (sampleEvent && capturing) begin
          if (decimCnt == Ctl_Decim) decimCnt <= '0;
          else                       decimCnt <= decimCnt + 8'd1;
        end
        if (doWrite) begin
          wrPtr     <= wrPtr + ONE_PTR;
          storedCnt <= storedCnt + ONE_CNT;
        end
        if (doPop) rdPtr <= rdPtr + ONE_PTR;
        if (doDrop) Stat_Overflow <= 1'b1;
        case ({doWrite, doPop})
          2'b10:   level <= level + ONE_CNT;
          2'b01:   level <= level - ONE_CNT;
          default: level <= level;
        endcase
      end
    end
  end

  assign Stat_Busy  = (state == CAPTURE);
  assign Stat_Done  = (state == DONE);
  assign Stat_Level = level;

endmodule

// File: tb/tb_adc_capture_core.sv
// Directed bench for adc_capture_core: hand-computed expectations checked with
// immediate assertions.
module tb_adc_capture_core;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  adcData;
  logic        adcOtr;
  logic        adcDClk;
  logic        adcPwrdn;
  logic        ctlPwrDn;
  logic        ctlStart;
  logic        ctlStop;
  logic [7:0]  ctlDecim;
  logic [9:0]  ctlCount;
  logic        rdReq;
  logic        rdAck;
  logic [0:31] rdData;
  logic        statBusy;
  logic        statDone;
  logic        statOverflow;
  logic [9:0]  statLevel;
  logic        captureIrq;

  int cmpCnt = 0;
  int errCnt = 0;
  int irqCnt = 0;

  adc_capture_core #(.ADC_WIDTH(10), .DEPTH_LOG2(9)) dut (
    .SPLB_Clk      (clk),
    .SPLB_Rst      (rst),
    .ADC_Data      (adcData),
    .ADC_OTR       (adcOtr),
    .ADC_DClk      (adcDClk),
    .ADC_PWRDN     (adcPwrdn),
    .Ctl_PwrDn     (ctlPwrDn),
    .Ctl_Start     (ctlStart),
    .Ctl_Stop      (ctlStop),
    .Ctl_Decim     (ctlDecim),
    .Ctl_Count     (ctlCount),
    .Rd_Req        (rdReq),
    .Rd_Ack        (rdAck),
    .Rd_Data       (rdData),
    .Stat_Busy     (statBusy),
    .Stat_Done     (statDone),
    .Stat_Overflow (statOverflow),
    .Stat_Level    (statLevel),
    .Capture_Irq   (captureIrq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (captureIrq === 1'b1) irqCnt++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmpCnt++;
    assert (obs === exp) else begin
      errCnt++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Data is set two cycles before DClk rises and held eight cycles after.
  task automatic sendSample(input logic [9:0] v, input logic o);
    adcData = v;
    adcOtr  = o;
    ticks(2);
    adcDClk = 1'b1;
    ticks(4);
    adcDClk = 1'b0;
    ticks(4);
  endtask

  task automatic pulseStart();
    ctlStart = 1'b1;
    tick();
    ctlStart = 1'b0;
  endtask

  task automatic doRead(output logic [31:0] data, output logic ack);
    rdReq = 1'b1;
    tick();
    rdReq = 1'b0;
    ack  = rdAck;
    data = rdData;
  endtask

  logic [31:0] rd;
  logic        ack;

  initial begin
    rst = 1'b1; adcData = '0; adcOtr = 1'b0; adcDClk = 1'b0;
    ctlPwrDn = 1'b0; ctlStart = 1'b0; ctlStop = 1'b0;
    ctlDecim = 8'd0; ctlCount = 10'd0; rdReq = 1'b0;

    // Reset state
    ticks(3);
    check("rst_pwrdn", adcPwrdn, 1);
    check("rst_ack", rdAck, 0);
    check("rst_data", rdData, 0);
    check("rst_level", statLevel, 0);
    check("rst_busy", statBusy, 0);
    check("rst_done", statDone, 0);
    check("rst_ovf", statOverflow, 0);
    check("rst_irq", captureIrq, 0);
    rst = 1'b0;
    tick();
    check("pwrdn_follow", adcPwrdn, 0);

    // Empty read still acknowledged, returns zero
    doRead(rd, ack);
    check("empty_ack", ack, 1);
    check("empty_data", rd, 32'h0);
    tick();
    check("ack_drop", rdAck, 0);
    check("data_idle_zero", rdData, 32'h0);

    // Stop while idle is ignored
    ctlStop = 1'b1; tick(); ctlStop = 1'b0;
    check("stop_idle_done", statDone, 0);
    check("stop_idle_busy", statBusy, 0);

    // Count-limited capture, no decimation
    ctlDecim = 8'd0; ctlCount = 10'd4; irqCnt = 0;
    pulseStart();
    check("t2_busy", statBusy, 1);
    for (int i = 1; i <= 6; i++) sendSample(10'(i), 1'b0);
    check("t2_level", statLevel, 4);
    check("t2_done", statDone, 1);
    check("t2_irq_once", irqCnt, 1);
    for (int i = 1; i <= 4; i++) begin
      doRead(rd, ack);
      check("t2_read_ack", ack, 1);
      check("t2_read_data", rd, 32'h8000_0000 | 32'(i));
    end
    check("t2_level_drained", statLevel, 0);

    // Decimate by 3, with OTR on samples 2 and 3
    ctlDecim = 8'd2; ctlCount = 10'd3; irqCnt = 0;
    pulseStart();
    check("t3_done_cleared", statDone, 0);
    for (int i = 1; i <= 9; i++) sendSample(10'(i), (i == 2 || i == 3));
    check("t3_level", statLevel, 3);
    check("t3_done", statDone, 1);
    check("t3_irq_once", irqCnt, 1);
    doRead(rd, ack); check("t3_rd0", rd, 32'hC000_0003);
    doRead(rd, ack); check("t3_rd1", rd, 32'h8000_0006);
    doRead(rd, ack); check("t3_rd2", rd, 32'h8000_0009);

    // Continuous capture into a full FIFO
    ctlDecim = 8'd0; ctlCount = 10'd0; irqCnt = 0;
    pulseStart();
    for (int i = 1; i <= 520; i++) sendSample(10'(i), 1'b0);
    check("t4_level_full", statLevel, 512);
    check("t4_overflow", statOverflow, 1);
    check("t4_still_busy", statBusy, 1);
    ctlStop = 1'b1; tick(); ctlStop = 1'b0;
    check("t4_stop_done", statDone, 1);
    check("t4_stop_irq", irqCnt, 1);
    doRead(rd, ack);
    check("t4_first_entry", rd, 32'h8000_0001);
    check("t4_level_after_pop", statLevel, 511);
    check("t4_ovf_sticky", statOverflow, 1);
    pulseStart();
    check("t4_restart_level", statLevel, 0);
    check("t4_restart_ovf", statOverflow, 0);
    check("t4_restart_busy", statBusy, 1);

    // Same-edge write and pop at level 5
    for (int i = 1; i <= 5; i++) sendSample(10'(i), 1'b0);
    check("t5_level5", statLevel, 5);
    adcData = 10'd6; adcOtr = 1'b0;
    ticks(2);
    adcDClk = 1'b1;
    ticks(2);
    rdReq = 1'b1;
    tick();
    rdReq = 1'b0;
    check("t5_ack", rdAck, 1);
    check("t5_data", rdData, 32'h8000_0001);
    check("t5_level_hold", statLevel, 5);
    ticks(2);
    adcDClk = 1'b0;
    ticks(4);
    check("t5_level_settled", statLevel, 5);

    // Start wins over a same-cycle Stop
    ctlStart = 1'b1; ctlStop = 1'b1;
    tick();
    ctlStart = 1'b0; ctlStop = 1'b0;
    check("t5_start_busy", statBusy, 1);
    check("t5_start_done", statDone, 0);
    check("t5_start_level", statLevel, 0);

    // Reset mid-capture with a pending read
    for (int i = 1; i <= 7; i++) sendSample(10'(i), 1'b0);
    check("t6_level7", statLevel, 7);
    rst = 1'b1; rdReq = 1'b1;
    tick();
    rst = 1'b0; rdReq = 1'b0;
    check("t6_busy", statBusy, 0);
    check("t6_done", statDone, 0);
    check("t6_level", statLevel, 0);
    check("t6_ack", rdAck, 0);
    check("t6_pwrdn", adcPwrdn, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, errCnt);
    $finish;
  end

endmodule

// File: doc/adc_capture_core.md
Name: adc_capture_core

Overview:
Receive-side counterpart of the PLB DAC core. Captures parallel ADC samples, strobed by the converter's own data clock, into the SPLB_Clk domain. Applies programmable decimation and buffers samples in an internal FIFO. Software drains the FIFO through a single-word read handshake driven by the PLB slave register logic. Sits between the ADC pins and the PLB slave attachment of the ADC peripheral.

Parameters:
ADC_WIDTH, 10, sample width in bits
DEPTH_LOG2, 9, FIFO depth = 2**DEPTH_LOG2 entries (512)

Ports:
SPLB_Clk  in  1  bus clock; all logic on rising edge
SPLB_Rst  in  1  synchronous active-high reset
ADC_Data  in  ADC_WIDTH  converter parallel output, asynchronous to SPLB_Clk
ADC_OTR  in  1  converter out-of-range flag, qualified with ADC_Data
ADC_DClk  in  1  converter data clock, asynchronous
ADC_PWRDN  out  1  converter power-down
Ctl_PwrDn  in  1  software power-down request
Ctl_Start  in  1  one-cycle pulse: flush FIFO and begin capture
Ctl_Stop  in  1  one-cycle pulse: end capture
Ctl_Decim  in  8  keep 1 of (Ctl_Decim+1) samples
Ctl_Count  in  DEPTH_LOG2+1  samples to store; 0 = continuous
Rd_Req  in  1  one-cycle read request
Rd_Ack  out  1  read acknowledge
Rd_Data  out  32  read word, bit 0 = MSB
Stat_Busy  out  1  state is CAPTURE
Stat_Done  out  1  state is DONE
Stat_Overflow  out  1  sticky: a sample was dropped because the FIFO was full
Stat_Level  out  DEPTH_LOG2+1  current FIFO occupancy
Capture_Irq  out  1  one-cycle pulse on entry to DONE

Behaviour:
- Reset values:
  - ADC_PWRDN=1; all other outputs 0.
  - FIFO empty, state IDLE, decimation counter 0, stored-sample counter 0.
- Sample strobe:
  - ADC_DClk passes through a 2-flop synchroniser plus one history flop.
  - A sample event is synchronised-high with history-low. Event latency is 3 SPLB_Clk cycles from the DClk rising edge.
  - ADC_Data/ADC_OTR are registered on every SPLB_Clk through a matching 2-stage pipeline; the value at the event cycle is the sample.
  - The converter holds data stable for at least 4 SPLB_Clk cycles around DClk rise.
- ADC_PWRDN: registered copy of Ctl_PwrDn, 1-cycle latency.
- FSM states IDLE, CAPTURE, DONE:
  - Ctl_Start (any state) -> CAPTURE. FIFO flushed, Stat_Overflow cleared, counters cleared. Start has priority over a same-cycle Stop, write, or read pop.
  - CAPTURE + Ctl_Stop -> DONE.
  - CAPTURE + stored count reaches Ctl_Count (Ctl_Count != 0) -> DONE on the cycle after the final write.
  - Ctl_Stop in IDLE or DONE is ignored.
  - DONE holds until the next Ctl_Start. Reads remain allowed in IDLE and DONE.
- Decimation, in CAPTURE only:
  - On each event, if decim_cnt == Ctl_Decim, store the sample and set decim_cnt=0; otherwise increment decim_cnt.
  - Ctl_Decim=0 stores every sample; 255 stores 1 of 256.
- Store:
  - If the FIFO is not full, write {OTR, sample} and increment the stored counter.
  - If the FIFO is full, drop the sample, set Stat_Overflow, and do not increment the stored counter.
  - Events outside CAPTURE are discarded.
- Capture_Irq pulses exactly once per transition into DONE.
- Read:
  - Rd_Req sampled at edge N; Rd_Ack=1 and Rd_Data valid during cycle N+1 only.
  - Non-empty FIFO: Rd_Data[0]=1 (valid), [1]=OTR, [32-ADC_WIDTH:31]=sample zero-extended, other bits 0; entry popped.
  - Empty FIFO: Rd_Ack still asserted, Rd_Data=0, no pop.
  - Rd_Req while Rd_Ack is high is legal; back-to-back requests yield back-to-back acks.
  - Rd_Data=0 whenever Rd_Ack=0.
- Simultaneous write and pop: both take effect, Stat_Level unchanged. A write when full with a same-cycle pop still counts as full and is dropped.
- Pointers wrap modulo 2**DEPTH_LOG2. Stat_Level ranges 0..2**DEPTH_LOG2 and reflects the FIFO state after the current cycle's operations.
- SPLB_Rst mid-capture returns to the reset values on the next edge; a pending read is not acknowledged.

Test Plan:
- Reset, then Ctl_PwrDn=0 -> ADC_PWRDN=1 during reset, 0 one cycle after reset deasserts; Rd_Req on empty FIFO -> Rd_Ack at N+1 with Rd_Data=0.
- Ctl_Decim=0, Ctl_Count=4, DClk period 10 cycles, samples 0x001..0x006 -> 4 entries (0x001..0x004); DONE; Capture_Irq pulses once; four reads return 0x80000001..0x80000004.
- Ctl_Decim=2, Ctl_Count=3, samples 1..9 -> FIFO holds 3, 6, 9; sample 2 with OTR=1 is not stored; a later OTR=1 on sample 3 gives 0xC0000003.
- Ctl_Count=0, DEPTH_LOG2=9, 520 samples with no reads -> Stat_Level=512, Stat_Overflow=1, 8 dropped; Ctl_Stop -> DONE; Ctl_Start -> Stat_Level=0, Overflow=0.
- Rd_Req at the same cycle as a sample write with level 5 -> level stays 5; Ctl_Start with Ctl_Stop in the same cycle -> state CAPTURE.
- SPLB_Rst asserted mid-capture with level 7 -> next cycle IDLE, Stat_Level=0, Rd_Ack=0, ADC_PWRDN=1.
